seg_scan: RTL and testbench

//   Time-multiplexed 7-segment display scanner downstream of the fst core.

---
 rtl/seg_scan.sv | 180 ++++++++++++++++++
 tb/tb_seg_scan.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan.sv
// ---------------------------------------------------------------------------
// seg_scan
//   Time-multiplexed 7-segment display scanner. Takes eight per-digit segment
//   patterns and drives one shared segment bus plus a one-hot digit select.
//   A blanking gap separates consecutive digits to suppress ghosting.
//   All eight patterns are snapshotted at the start of each frame, so a
//   digit cannot tear while the upstream core is updating it.
//
//   Scan sequence: BLANK (BLANK cycles) -> SHOW digit idx (DIV cycles) ->
//   BLANK -> SHOW digit idx+1 ... -> digit 7 -> wrap to digit 0.
//   Frame period = 8*(DIV+BLANK) cycles.
//
// Parameters
//   DIV        cycles each digit is shown, >= 1
//   BLANK      cycles all digits are dark between digits, >= 1
//   ACTIVE_LOW 1: seg_out and dig_sel are active-low (lit bit = 0)
//
// Ports
//   clk_in      in   clock, all state changes on the rising edge
//   reset_in    in   synchronous reset, active-high, highest priority
//   enable      in   1 = scan; 0 = force dark and restart at digit 0
//   seg_a..h    in   segment patterns of digits 0..7 (bit=1 lit, bit7 = dp)
//   seg_out     out  shared segment bus (registered)
//   dig_sel     out  one-hot digit select, bit i = digit i (registered)
//   frame_tick  out  one-cycle pulse in the first SHOW cycle of digit 0
//
// There is no valid/ready handshake: the seg_* inputs are level signals
// that are simply sampled once per frame.
// ---------------------------------------------------------------------------
module seg_scan #(
    parameter int DIV        = 4,
    parameter int BLANK      = 2,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       enable,
    input  logic [7:0] seg_a,
    input  logic [7:0] seg_b,
    input  logic [7:0] seg_c,
    input  logic [7:0] seg_d,
    input  logic [7:0] seg_e,
    input  logic [7:0] seg_f,
    input  logic [7:0] seg_g,
    input  logic [7:0] seg_h,
    output logic [7:0] seg_out,
    output logic [7:0] dig_sel,
    output logic       frame_tick
);

    // Phase counter only has to reach the longer of the two phases.
    localparam int MAX_CNT = (DIV > BLANK) ? DIV : BLANK;
    localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);

    // Value that means "dark" on both output buses; also used as the XOR
    // mask that converts active-high internal values to the pin polarity.
    localparam logic [7:0] OFF_VAL = ACTIVE_LOW ? 8'hFF : 8'h00;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    // FSM state kept as named registers so checkers can bind to them.
    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    snap [8];

    // Inputs gathered into an array so the digit index can address them.
    logic [7:0] seg_in [8];

    always_comb begin
        seg_in[0] = seg_a;
        seg_in[1] = seg_b;
        seg_in[2] = seg_c;
        seg_in[3] = seg_d;
        seg_in[4] = seg_e;
        seg_in[5] = seg_f;
        seg_in[6] = seg_g;
        seg_in[7] = seg_h;
    end

    // -----------------------------------------------------------------------
    // Next-state decode
    // -----------------------------------------------------------------------
    state_t        nxt_state;
    logic [CW-1:0] nxt_cnt;
    logic [2:0]    nxt_idx;
    logic          load_snap;

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt + CW'(1);
        nxt_idx   = idx;
        load_snap = 1'b0;
        case (state)
            ST_BLANK: begin
                if (cnt == BLANK_LAST) begin
                    nxt_state = ST_SHOW;
                    nxt_cnt   = '0;
                    // Entering digit 0 starts a new frame: take the snapshot.
                    load_snap = (idx == 3'd0);
                end
            end
            ST_SHOW: begin
                if (cnt == DIV_LAST) begin
                    nxt_state = ST_BLANK;
                    nxt_cnt   = '0;
                    nxt_idx   = idx + 3'd1;  // 7 wraps to 0 naturally
                end
            end
            default: begin
                nxt_state = ST_BLANK;
                nxt_cnt   = '0;
                nxt_idx   = 3'd0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode for the next state. The outputs are registered on the
    // same edge as the state, so the value is derived from next-state terms.
    // On the frame-start edge the snapshot is still being written, so the
    // pattern for digit 0 comes straight from the input instead.
    // -----------------------------------------------------------------------
    logic [7:0] nxt_pattern;
    logic [7:0] nxt_onehot;

    always_comb begin
        nxt_pattern = load_snap ? seg_in[0] : snap[nxt_idx];
        nxt_onehot  = 8'h01 << nxt_idx;
    end

    // -----------------------------------------------------------------------
    // FSM, snapshot and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state      <= ST_BLANK;
            cnt        <= '0;
            idx        <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                snap[i] <= 8'h00;
            end
            seg_out    <= OFF_VAL;
            dig_sel    <= OFF_VAL;
            frame_tick <= 1'b0;
        end else if (!enable) begin
            // Same restart as reset, but the last snapshot is kept.
            state      <= ST_BLANK;
            cnt        <= '0;
            idx        <= 3'd0;
            seg_out    <= OFF_VAL;
            dig_sel    <= OFF_VAL;
            frame_tick <= 1'b0;
        end else begin
            state      <= nxt_state;
            cnt        <= nxt_cnt;
            idx        <= nxt_idx;
            frame_tick <= load_snap;
            if (load_snap) begin
                for (int i = 0; i < 8; i++) begin
                    snap[i] <= seg_in[i];
                end
            end
            if (nxt_state == ST_SHOW) begin
                seg_out <= nxt_pattern ^ OFF_VAL;
                dig_sel <= nxt_onehot ^ OFF_VAL;
            end else begin
                seg_out <= OFF_VAL;
                dig_sel <= OFF_VAL;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// ---------------------------------------------------------------------------
// tb_seg_scan
//   Directed bench for seg_scan with DIV=4, BLANK=2. One instance uses
//   active-high outputs, a second one uses ACTIVE_LOW=1; both share inputs.
//   Cycle numbering: cycle 0 is the first cycle after the last reset edge.
//   Outputs are sampled at the falling edge; inputs change there too.
// ---------------------------------------------------------------------------
module tb_seg_scan;

    logic       clk_in;
    logic       reset_in;
    logic       enable;
    logic [7:0] seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g, seg_h;
    logic [7:0] seg_out, dig_sel;
    logic       frame_tick;
    logic [7:0] seg_out_al, dig_sel_al;
    logic       frame_tick_al;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference patterns of scenario 2 (digits 0..7)
    logic [7:0] pat [8] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07};

    seg_scan #(.DIV(4), .BLANK(2), .ACTIVE_LOW(1'b0)) dut (
        .clk_in     (clk_in),
        .reset_in   (reset_in),
        .enable     (enable),
        .seg_a      (seg_a),
        .seg_b      (seg_b),
        .seg_c      (seg_c),
        .seg_d      (seg_d),
        .seg_e      (seg_e),
        .seg_f      (seg_f),
        .seg_g      (seg_g),
        .seg_h      (seg_h),
        .seg_out    (seg_out),
        .dig_sel    (dig_sel),
        .frame_tick (frame_tick)
    );

    seg_scan #(.DIV(4), .BLANK(2), .ACTIVE_LOW(1'b1)) dut_al (
        .clk_in     (clk_in),
        .reset_in   (reset_in),
        .enable     (enable),
        .seg_a      (seg_a),
        .seg_b      (seg_b),
        .seg_c      (seg_c),
        .seg_d      (seg_d),
        .seg_e      (seg_e),
        .seg_f      (seg_f),
        .seg_g      (seg_g),
        .seg_h      (seg_h),
        .seg_out    (seg_out_al),
        .dig_sel    (dig_sel_al),
        .frame_tick (frame_tick_al)
    );

    // ---------------- clock / reset ----------------
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // ---------------- timing model (DIV=4, BLANK=2) ----------------
    // Each digit slot is 6 cycles: 2 blank then 4 shown; frame = 48 cycles.
    function automatic int model_digit(input int c);
        return (c % 48) / 6;
    endfunction

    function automatic bit model_show(input int c);
        return ((c % 48) % 6) >= 2;
    endfunction

    function automatic logic [7:0] model_dig(input int c);
        logic [7:0] one;
        one = 8'h01;
        return model_show(c) ? (one << model_digit(c)) : 8'h00;
    endfunction

    function automatic logic model_tick(input int c);
        return (c % 48) == 2;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk_in);
        @(negedge clk_in);
        cyc++;
    endtask

    task automatic load_patterns();
        seg_a = pat[0]; seg_b = pat[1]; seg_c = pat[2]; seg_d = pat[3];
        seg_e = pat[4]; seg_f = pat[5]; seg_g = pat[6]; seg_h = pat[7];
    endtask

    task automatic randomize_inputs();
        seg_a = 8'($urandom_range(255)); seg_b = 8'($urandom_range(255));
        seg_c = 8'($urandom_range(255)); seg_d = 8'($urandom_range(255));
        seg_e = 8'($urandom_range(255)); seg_f = 8'($urandom_range(255));
        seg_g = 8'($urandom_range(255)); seg_h = 8'($urandom_range(255));
    endtask

    // Reset for 3 edges and leave the bench at cycle 0 with patterns loaded.
    task automatic apply_reset();
        @(negedge clk_in);
        reset_in = 1'b1;
        enable   = 1'b1;
        randomize_inputs();
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        reset_in = 1'b0;
        load_patterns();
        cyc = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk_in);
        reset_in = 1'b1;
        enable   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            randomize_inputs();
            @(posedge clk_in);
            @(negedge clk_in);
            checks++;
            if (seg_out !== 8'h00 || dig_sel !== 8'h00 || frame_tick !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold[%0d] seg_out=%h dig_sel=%h tick=%b exp 00/00/0",
                         i, seg_out, dig_sel, frame_tick);
            end
            checks++;
            if (seg_out_al !== 8'hFF || dig_sel_al !== 8'hFF || frame_tick_al !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold_al[%0d] seg_out=%h dig_sel=%h tick=%b exp FF/FF/0",
                         i, seg_out_al, dig_sel_al, frame_tick_al);
            end
        end
        reset_in = 1'b0;
        cyc = 0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (seg_out !== 8'h00 || dig_sel !== 8'h00 || frame_tick !== 1'b0) begin
                errors++;
                $display("FAIL reset_release cyc=%0d seg_out=%h dig_sel=%h tick=%b exp 00/00/0",
                         cyc, seg_out, dig_sel, frame_tick);
            end
            step();
        end
    endtask

    task automatic test_scan();
        logic [7:0] exp_dig, exp_seg;
        apply_reset();
        for (int c = 0; c <= 55; c++) begin
            exp_dig = model_dig(c);
            exp_seg = model_show(c) ? pat[model_digit(c)] : 8'h00;
            checks++;
            if (dig_sel !== exp_dig) begin
                errors++;
                $display("FAIL scan_dig cyc=%0d got=%h exp=%h", cyc, dig_sel, exp_dig);
            end
            checks++;
            if (seg_out !== exp_seg) begin
                errors++;
                $display("FAIL scan_seg cyc=%0d got=%h exp=%h", cyc, seg_out, exp_seg);
            end
            checks++;
            if (frame_tick !== model_tick(c)) begin
                errors++;
                $display("FAIL scan_tick cyc=%0d got=%b exp=%b", cyc, frame_tick, model_tick(c));
            end
            step();
        end
    endtask

    task automatic test_tearing();
        logic [7:0] exp_seg;
        apply_reset();
        for (int c = 0; c <= 55; c++) begin
            if (c == 20) seg_a = 8'h66;
            if (model_show(c) && model_digit(c) == 0) begin
                exp_seg = (c >= 48) ? 8'h66 : 8'h3F;
                checks++;
                if (seg_out !== exp_seg || dig_sel !== 8'h01) begin
                    errors++;
                    $display("FAIL tearing cyc=%0d seg_out=%h dig_sel=%h exp %h/01",
                             cyc, seg_out, dig_sel, exp_seg);
                end
            end
            step();
        end
    endtask

    task automatic test_enable();
        logic [7:0] exp_dig, exp_seg;
        apply_reset();
        for (int c = 0; c <= 9; c++) begin
            exp_dig = model_dig(c);
            checks++;
            if (dig_sel !== exp_dig) begin
                errors++;
                $display("FAIL en_pre_dig cyc=%0d got=%h exp=%h", cyc, dig_sel, exp_dig);
            end
            if (c == 9) enable = 1'b0;
            step();
        end
        // cycle 10: first dark cycle after enable dropped mid digit 1
        checks++;
        if (seg_out !== 8'h00 || dig_sel !== 8'h00 || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL en_off cyc=%0d seg_out=%h dig_sel=%h tick=%b exp 00/00/0",
                     cyc, seg_out, dig_sel, frame_tick);
        end
        step();
        // cycle 11: re-enable with a new digit 0 pattern; this is the new cycle 0
        seg_a  = 8'h71;
        enable = 1'b1;
        for (int c = 0; c <= 13; c++) begin
            exp_dig = model_dig(c);
            exp_seg = !model_show(c) ? 8'h00 :
                      (model_digit(c) == 0) ? 8'h71 : pat[model_digit(c)];
            checks++;
            if (dig_sel !== exp_dig || seg_out !== exp_seg) begin
                errors++;
                $display("FAIL en_restart cyc=%0d dig_sel=%h seg_out=%h exp %h/%h",
                         cyc, dig_sel, seg_out, exp_dig, exp_seg);
            end
            checks++;
            if (frame_tick !== model_tick(c)) begin
                errors++;
                $display("FAIL en_tick cyc=%0d got=%b exp=%b", cyc, frame_tick, model_tick(c));
            end
            step();
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] exp_dig, exp_seg;
        apply_reset();
        for (int c = 0; c <= 30; c++) begin
            if (c == 28) begin
                checks++;
                if (dig_sel !== 8'h10 || seg_out !== pat[4]) begin
                    errors++;
                    $display("FAIL mid_pre cyc=%0d dig_sel=%h seg_out=%h exp 10/%h",
                             cyc, dig_sel, seg_out, pat[4]);
                end
            end
            if (c == 30) reset_in = 1'b1;
            step();
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (seg_out !== 8'h00 || dig_sel !== 8'h00 || frame_tick !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset cyc=%0d seg_out=%h dig_sel=%h tick=%b exp 00/00/0",
                         cyc, seg_out, dig_sel, frame_tick);
            end
            if (i == 1) reset_in = 1'b0;
            step();
        end
        // The cycle after the last reset edge was the one just checked (new cycle 0),
        // so the bench now sits at new cycle 1.
        for (int c = 1; c <= 13; c++) begin
            exp_dig = model_dig(c);
            exp_seg = model_show(c) ? pat[model_digit(c)] : 8'h00;
            checks++;
            if (dig_sel !== exp_dig || seg_out !== exp_seg || frame_tick !== model_tick(c)) begin
                errors++;
                $display("FAIL mid_restart cyc=%0d dig_sel=%h seg_out=%h tick=%b exp %h/%h/%b",
                         c, dig_sel, seg_out, frame_tick, exp_dig, exp_seg, model_tick(c));
            end
            step();
        end
    endtask

    task automatic test_active_low();
        logic [7:0] exp_dig, exp_seg;
        apply_reset();
        for (int c = 0; c <= 13; c++) begin
            // 3F inverted is C0; digit 0 select inverted is FE; digit 1 FD / F9.
            exp_dig = ~model_dig(c);
            exp_seg = model_show(c) ? ~pat[model_digit(c)] : 8'hFF;
            checks++;
            if (dig_sel_al !== exp_dig || seg_out_al !== exp_seg) begin
                errors++;
                $display("FAIL active_low cyc=%0d dig_sel=%h seg_out=%h exp %h/%h",
                         cyc, dig_sel_al, seg_out_al, exp_dig, exp_seg);
            end
            checks++;
            if (frame_tick_al !== model_tick(c)) begin
                errors++;
                $display("FAIL active_low_tick cyc=%0d got=%b exp=%b",
                         cyc, frame_tick_al, model_tick(c));
            end
            step();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset_in = 1'b1;
        enable   = 1'b1;
        randomize_inputs();
        test_reset();
        test_scan();
        test_tearing();
        test_enable();
        test_mid_reset();
        test_active_low();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
